// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - reset/clock-enable sequencer: sync reset release, settle hold, sync-reset pulse, user clock enable
// Optional macro RST_SEQ_STATUS_EN adds o_sw_reset_count (saturating count of software reset requests).
module rst_seq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int SRST_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       async_reset_n,
  input  logic       sw_reset_req,
  input  logic       clk_en_req,
  output logic       o_reset_n_sync,
  output logic       o_sync_reset,
  output logic       o_clk_en,
  output logic       o_ready,
`ifdef RST_SEQ_STATUS_EN
  output logic [7:0] o_sw_reset_count,
`endif
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_SRST  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SRST_LOAD = CNT_W'(SRST_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   en_q, en_d;
  logic                   srst_q, clk_en_q, ready_q;
`ifdef RST_SEQ_STATUS_EN
  logic [7:0]             swcnt_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET: begin
        if (sync_q[SYNC_STAGES-1]) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_SRST;
          cnt_d   = SRST_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SRST: begin
        // A request while pulsing stretches the pulse rather than queueing another.
        if (sw_reset_req) begin
          cnt_d = SRST_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (sw_reset_req) begin
          state_d = ST_SRST;
          cnt_d   = SRST_LOAD;
        end
      end
    endcase
    en_d = (state_d == ST_RUN) ? clk_en_req : 1'b0;
  end

  // Outputs are flopped from next-state so the clock-gate enable never glitches.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sync_q   <= '0;
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      srst_q   <= 1'b0;
      clk_en_q <= 1'b0;
      ready_q  <= 1'b0;
`ifdef RST_SEQ_STATUS_EN
      swcnt_q  <= '0;
`endif
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      srst_q   <= (state_d == ST_SRST);
      clk_en_q <= (state_d == ST_SRST) || ((state_d == ST_RUN) && en_d);
      ready_q  <= (state_d == ST_RUN);
`ifdef RST_SEQ_STATUS_EN
      if ((state_q == ST_RUN) && sw_reset_req && (swcnt_q != 8'hFF)) begin
        swcnt_q <= swcnt_q + 8'd1;
      end
`endif
    end
  end

  assign o_reset_n_sync = sync_q[SYNC_STAGES-1];
  assign o_sync_reset   = srst_q;
  assign o_clk_en       = clk_en_q;
  assign o_ready        = ready_q;
  assign o_state        = state_q;
`ifdef RST_SEQ_STATUS_EN
  assign o_sw_reset_count = swcnt_q;
`endif

endmodule
